mig_ui_arbiter: RTL and testbench
=================================

Name: mig_ui_arbiter

Overview:
Two-client arbiter in front of the MIG user interface (app_* command, write-data and read-return channels), clocked by ui_clk.
- Accepts one full-line (512-bit) read or write request at a time from either client, using round-robin arbitration.
- For writes, drives the command and write-data channels together and retires each independently.
- Tags every accepted read so in-order MIG read returns are routed back to the client that issued them.
- Sits between the traffic generators / DMA clients and the MIG core.

Parameters:
- ADDR_W, 28, app_addr width
- DATA_W, 512, app data width
- MASK_W, 64, byte-mask width (DATA_W/8)
- TAGQ_DEPTH, 32, max outstanding reads (power of 2, >=2)

Ports:
- ui_clk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-high
- init_calib_complete  in  1  no command issued while low
- c_req  in  2  per-client request, held stable until c_gnt
- c_we  in  2  per-client 1=write, 0=read
- c_addr  in  2*ADDR_W  packed addresses, client0 in low slice
- c_wdata  in  2*DATA_W  packed write data
- c_wmask  in  2*MASK_W  packed write masks (1=byte masked)
- c_gnt  out  2  one-cycle pulse: request fully accepted by MIG
- c_rd_data  out  DATA_W  read data, broadcast to both clients
- c_rd_valid  out  2  one-hot, marks the owning client of c_rd_data
- app_addr  out  ADDR_W  MIG address
- app_cmd  out  3  0=write, 1=read
- app_en  out  1  command valid
- app_rdy  in  1  command accepted when app_en&app_rdy
- app_wdf_data  out  DATA_W  write data
- app_wdf_mask  out  MASK_W  write mask
- app_wdf_wren  out  1  write-data valid
- app_wdf_end  out  1  equals app_wdf_wren (single-beat line)
- app_wdf_rdy  in  1  write data accepted when wren&wdf_rdy
- app_rd_data  in  DATA_W  MIG read data
- app_rd_data_valid  in  1  MIG read data valid
- rd_err  out  1  sticky: read valid arrived with no outstanding tag

Behaviour:
- Reset (async, any state): all outputs 0; state IDLE; rr pointer=client0 preferred; tag FIFO emptied; rd_err cleared. Outstanding reads are discarded.

States:
- IDLE
  - Requires init_calib_complete=1.
  - Picks a client with c_req=1. A read request is eligible only if the tag FIFO is not full.
  - If both clients are eligible, picks the one not granted last (rr pointer). If only one is eligible, picks that one.
  - Registers addr, cmd, wdata and wmask from the chosen slice; sets owner.
  - Next cycle: app_en=1, plus app_wdf_wren=app_wdf_end=1 for a write. Go to ISSUE.
  - Latency: one cycle from sampled c_req to app_en.
- ISSUE
  - app_en drops the cycle after app_en&app_rdy.
  - app_wdf_wren/app_wdf_end drop the cycle after wren&app_wdf_rdy.
  - The two write handshakes may complete in either order or in the same cycle.
  - The request is done in the cycle its last outstanding handshake completes. In that cycle:
    - c_gnt[owner]=1, combinational from the handshake, so exactly one pulse;
    - rr pointer is updated to favour the other client;
    - state returns to IDLE.
  - A read pushes owner into the tag FIFO in its app_rdy handshake cycle.
  - The client may change c_req/c_addr on the edge after c_gnt. IDLE samples the new values.
- init_calib_complete falling mid-ISSUE: the current request completes normally; no new request starts until it rises again.
- Address and data outputs stay stable while their enable is high (MIG rule). They hold their last values when idle.

Read return:
- On app_rd_data_valid with the FIFO non-empty:
  - pop the tag;
  - next cycle c_rd_data=registered app_rd_data and c_rd_valid=onehot(tag);
  - c_rd_valid is 0 otherwise.
- A push and a pop in the same cycle are both allowed; the count is unchanged. Full is evaluated before the push, so no overflow occurs.
- app_rd_data_valid with the FIFO empty: data dropped, rd_err=1 until reset.

Decomposition:
- Package mig_ui_pkg:
  - CMD_WRITE=3'd0, CMD_READ=3'd1
  - state enum {IDLE, ISSUE}
  - default widths
- Sub-module mig_tag_fifo:
  - 1-bit tag, TAGQ_DEPTH deep
  - push/pop/full/empty
  - count width clog2(TAGQ_DEPTH)+1
  - simultaneous push/pop supported

Test Plan:
1. Client0 write addr 0x40, data 0xA5.., app_rdy and app_wdf_rdy both high -> app_en and app_wdf_wren high for exactly 1 cycle, app_cmd=0; c_gnt[0] pulses once.
2. Client1 read addr 0x80, app_rdy held low 5 cycles -> app_en held 6 cycles with stable addr; c_gnt[1] in the accept cycle; returned data 0x1234 gives c_rd_valid=2'b10 with c_rd_data=0x1234 one cycle later.
3. Both clients request reads continuously, 8 grants -> grants alternate 0,1,0,1...; returns routed in issue order, one-hot matching.
4. Write with app_rdy high at cycle 1 but app_wdf_rdy only at cycle 4 (and reversed order) -> single c_gnt in cycle 4; no duplicate command or data beat.
5. TAGQ_DEPTH=4, 4 reads issued with no returns -> 5th read not issued (app_en stays 0) while a write from the other client still proceeds; one return re-enables the read.
6. Assert sys_rst mid-ISSUE with 2 reads outstanding -> all outputs 0 immediately; after release, a read valid with no tag sets rd_err=1 and c_rd_valid stays 0.

Source files
------------

// File: rtl/mig_ui_pkg.sv
// Shared types, command encodings and default widths for the MIG user-interface arbiter.
package mig_ui_pkg;

  localparam int unsigned ADDR_W_DEF     = 28;
  localparam int unsigned DATA_W_DEF     = 512;
  localparam int unsigned MASK_W_DEF     = 64;
  localparam int unsigned TAGQ_DEPTH_DEF = 32;

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;

  typedef enum logic {
    IDLE,
    ISSUE
  } arb_state_t;

  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mig_ui_arbiter_if.sv
// MIG app_* command, write-data and read-return channels.
import mig_ui_pkg::*;

interface mig_ui_arbiter_if #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned MASK_W = MASK_W_DEF
);
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/mig_tag_fifo.sv
// Owner-tag FIFO: one bit per outstanding read, popped as in-order read data returns.
import mig_ui_pkg::*;

module mig_tag_fifo #(
  parameter int unsigned DEPTH = TAGQ_DEPTH_DEF
) (
  input  logic ui_clk,
  input  logic sys_rst,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic pop_tag,
  output logic full,
  output logic empty
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned COUNT_W = PTR_W + 1;

  logic [DEPTH-1:0]   mem;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [COUNT_W-1:0] count;
  logic               do_push, do_pop;

  assign full    = (count == COUNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_tag = mem[rd_ptr];

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mig_ui_arbiter.sv
// Two-client round-robin arbiter issuing single-beat 512-bit lines to the MIG user interface.
import mig_ui_pkg::*;

module mig_ui_arbiter #(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MASK_W     = MASK_W_DEF,
  parameter int unsigned TAGQ_DEPTH = TAGQ_DEPTH_DEF
) (
  input  logic                ui_clk,
  input  logic                sys_rst,
  input  logic                init_calib_complete,
  input  logic [1:0]          c_req,
  input  logic [1:0]          c_we,
  input  logic [2*ADDR_W-1:0] c_addr,
  input  logic [2*DATA_W-1:0] c_wdata,
  input  logic [2*MASK_W-1:0] c_wmask,
  output logic [1:0]          c_gnt,
  output logic [DATA_W-1:0]   c_rd_data,
  output logic [1:0]          c_rd_valid,
  output logic                rd_err,
  mig_ui_arbiter_if.master    app
);
  arb_state_t state;
  logic       owner, rr;
  logic [1:0] elig;
  logic       pick, pick_valid;
  logic       cmd_hs, en_hold, wren_hold, done;
  logic       tag_push, tag_pop, tag_head, tag_full, tag_empty;

  always_comb begin
    elig       = c_req & (c_we | {2{~tag_full}});
    pick_valid = init_calib_complete & (elig != 2'b00);
    pick       = (elig == 2'b11) ? rr : elig[1];
  end

  // The request retires when neither enable survives into the next cycle.
  always_comb begin
    cmd_hs    = app.app_en & app.app_rdy;
    en_hold   = app.app_en & ~app.app_rdy;
    wren_hold = app.app_wdf_wren & ~app.app_wdf_rdy;
    done      = (state == ISSUE) & ~en_hold & ~wren_hold;
    c_gnt     = done ? onehot2(owner) : 2'b00;
    tag_push  = (state == ISSUE) & cmd_hs & (app.app_cmd == CMD_READ);
    tag_pop   = app.app_rd_data_valid & ~tag_empty;
  end

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state            <= IDLE;
      owner            <= 1'b0;
      rr               <= 1'b0;
      app.app_addr     <= '0;
      app.app_cmd      <= '0;
      app.app_en       <= 1'b0;
      app.app_wdf_data <= '0;
      app.app_wdf_mask <= '0;
      app.app_wdf_wren <= 1'b0;
      app.app_wdf_end  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner            <= pick;
            app.app_addr     <= pick ? c_addr[2*ADDR_W-1:ADDR_W]  : c_addr[ADDR_W-1:0];
            app.app_wdf_data <= pick ? c_wdata[2*DATA_W-1:DATA_W] : c_wdata[DATA_W-1:0];
            app.app_wdf_mask <= pick ? c_wmask[2*MASK_W-1:MASK_W] : c_wmask[MASK_W-1:0];
            app.app_cmd      <= c_we[pick] ? CMD_WRITE : CMD_READ;
            app.app_en       <= 1'b1;
            app.app_wdf_wren <= c_we[pick];
            app.app_wdf_end  <= c_we[pick];
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          app.app_en       <= en_hold;
          app.app_wdf_wren <= wren_hold;
          app.app_wdf_end  <= wren_hold;
          if (done) begin
            rr    <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      c_rd_data  <= '0;
      c_rd_valid <= 2'b00;
      rd_err     <= 1'b0;
    end else begin
      c_rd_valid <= tag_pop ? onehot2(tag_head) : 2'b00;
      if (tag_pop)
        c_rd_data <= app.app_rd_data;
      if (app.app_rd_data_valid && tag_empty)
        rd_err <= 1'b1;
    end
  end

  mig_tag_fifo #(.DEPTH(TAGQ_DEPTH)) u_tag_fifo (
    .ui_clk   (ui_clk),
    .sys_rst  (sys_rst),
    .push     (tag_push),
    .push_tag (owner),
    .pop      (tag_pop),
    .pop_tag  (tag_head),
    .full     (tag_full),
    .empty    (tag_empty)
  );
endmodule

// File: tb/tb_mig_ui_arbiter.sv
// Scoreboard bench for mig_ui_arbiter: expectations queued at stimulus time, checked by a monitor.
module tb_mig_ui_arbiter;
  import mig_ui_pkg::*;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 512;
  localparam int unsigned MW = 64;
  localparam int unsigned TD = 4;

  typedef struct packed { logic [AW-1:0] addr; logic [2:0] cmd; } cmd_t;
  typedef struct packed { logic [DW-1:0] data; logic [MW-1:0] mask; } wd_t;
  typedef struct packed { logic [1:0] v; logic [DW-1:0] d; } rd_t;

  logic ui_clk = 1'b0;
  logic sys_rst;
  logic init_calib_complete;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  logic [MW-1:0] wm0 = '0, wm1 = '0;
  logic [1:0]    c_gnt, c_rd_valid;
  logic [DW-1:0] c_rd_data;
  logic          rd_err;

  int   n_cmp = 0, n_bad = 0, outstanding = 0;
  bit   exp_gnt[$];
  cmd_t exp_cmd[$];
  wd_t  exp_wd[$];
  rd_t  exp_rd[$];

  mig_ui_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) app ();

  mig_ui_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .TAGQ_DEPTH(TD)) dut (
    .ui_clk              (ui_clk),
    .sys_rst             (sys_rst),
    .init_calib_complete (init_calib_complete),
    .c_req               ({req1, req0}),
    .c_we                ({we1, we0}),
    .c_addr              ({addr1, addr0}),
    .c_wdata             ({wd1, wd0}),
    .c_wmask             ({wm1, wm0}),
    .c_gnt               (c_gnt),
    .c_rd_data           (c_rd_data),
    .c_rd_valid          (c_rd_valid),
    .rd_err              (rd_err),
    .app                 (app)
  );

  always #5 ui_clk = ~ui_clk;

  function automatic cmd_t mk_cmd(input logic [AW-1:0] a, input logic [2:0] c);
    cmd_t r; r.addr = a; r.cmd = c; return r;
  endfunction
  function automatic wd_t mk_wd(input logic [DW-1:0] d, input logic [MW-1:0] m);
    wd_t r; r.data = d; r.mask = m; return r;
  endfunction
  function automatic rd_t mk_rd(input logic [1:0] v, input logic [DW-1:0] d);
    rd_t r; r.v = v; r.d = d; return r;
  endfunction

  task automatic chk(input string name, input logic [639:0] got, input logic [639:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %s expected event", name, what);
  endtask

  task automatic unexpected(input string name, input logic [639:0] got);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h expected nothing", name, got);
  endtask

  // Monitor: every DUT-side event pops its expectation.
  initial begin
    bit b; cmd_t c; wd_t w; rd_t r;
    forever begin
      @(negedge ui_clk);
      if (!sys_rst) begin
        if (c_gnt != 2'b00) begin
          if (exp_gnt.size() == 0) unexpected("gnt_extra", c_gnt);
          else begin b = exp_gnt.pop_front(); chk("gnt", c_gnt, onehot2(b)); end
        end
        if (app.app_en && app.app_rdy) begin
          if (app.app_cmd == CMD_READ) outstanding++;
          if (exp_cmd.size() == 0) unexpected("cmd_extra", {app.app_addr, app.app_cmd});
          else begin c = exp_cmd.pop_front(); chk("cmd", {app.app_addr, app.app_cmd}, c); end
        end
        if (app.app_wdf_wren && app.app_wdf_rdy) begin
          if (exp_wd.size() == 0) unexpected("wdata_extra", app.app_wdf_data);
          else begin
            w = exp_wd.pop_front();
            chk("wdata", {app.app_wdf_end, app.app_wdf_data, app.app_wdf_mask}, {1'b1, w});
          end
        end
        if (c_rd_valid != 2'b00) begin
          if (exp_rd.size() == 0) unexpected("rd_extra", {c_rd_valid, c_rd_data});
          else begin r = exp_rd.pop_front(); chk("rd_return", {c_rd_valid, c_rd_data}, r); end
        end
      end
    end
  end

  task automatic client_run(input int unsigned c, input logic we, input logic [AW-1:0] base,
                            input int unsigned n, input logic [DW-1:0] d, input logic [MW-1:0] m);
    for (int unsigned i = 0; i < n; i++) begin
      bit got = 1'b0;
      @(posedge ui_clk); #1;
      if (c == 0) begin req0 = 1'b1; we0 = we; addr0 = base + AW'(i * 16); wd0 = d; wm0 = m; end
      else        begin req1 = 1'b1; we1 = we; addr1 = base + AW'(i * 16); wd1 = d; wm1 = m; end
      for (int unsigned t = 0; t < 200 && !got; t++) begin
        @(negedge ui_clk);
        got = c_gnt[c];
      end
      if (!got) fail("client_gnt_timeout", "timeout");
    end
    @(posedge ui_clk); #1;
    if (c == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic wait_en();
    int unsigned t = 0;
    do begin @(negedge ui_clk); t++; end while (!app.app_en && t < 60);
    if (!app.app_en) fail("app_en_timeout", "timeout");
  endtask

  task automatic rd_return(input logic [DW-1:0] d, input logic [1:0] v);
    @(posedge ui_clk); #1;
    app.app_rd_data = d;
    app.app_rd_data_valid = 1'b1;
    if (v != 2'b00) exp_rd.push_back(mk_rd(v, d));
    @(posedge ui_clk); #1;
    app.app_rd_data_valid = 1'b0;
  endtask

  // Split-handshake write: first channel ready at cycle 1, second only at cycle 4.
  task automatic t4_run(input int unsigned c, input bit cmd_first, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
    app.app_rdy     = cmd_first;
    app.app_wdf_rdy = ~cmd_first;
    exp_gnt.push_back(c[0]);
    exp_cmd.push_back(mk_cmd(a, CMD_WRITE));
    exp_wd.push_back(mk_wd(d, m));
    fork
      client_run(c, 1'b1, a, 1, d, m);
      begin
        wait_en();
        repeat (2) begin
          @(negedge ui_clk);
          chk("t4_pending", {app.app_en, app.app_wdf_wren, c_gnt}, {~cmd_first, cmd_first, 2'b00});
        end
        @(posedge ui_clk); #1;
        app.app_rdy = 1'b1; app.app_wdf_rdy = 1'b1;
        @(negedge ui_clk);
        chk("t4_gnt_cycle4", c_gnt, onehot2(c[0]));
        @(negedge ui_clk);
        chk("t4_idle_after", {app.app_en, app.app_wdf_wren, c_gnt}, '0);
      end
    join
  endtask

  initial begin
    int unsigned hold, stalled, t;
    logic [AW-1:0] a;

    sys_rst = 1'b1; init_calib_complete = 1'b0;
    app.app_rdy = 1'b0; app.app_wdf_rdy = 1'b0;
    app.app_rd_data = '0; app.app_rd_data_valid = 1'b0;
    repeat (3) @(posedge ui_clk);
    @(negedge ui_clk);
    chk("reset_ctrl", {app.app_en, app.app_wdf_wren, app.app_wdf_end, c_gnt, c_rd_valid, rd_err}, '0);
    chk("reset_bus", {app.app_addr, app.app_cmd, app.app_wdf_mask, c_rd_data}, '0);
    sys_rst = 1'b0;

    // 1: single write, both channels ready; calibration gates the start.
    app.app_rdy = 1'b1; app.app_wdf_rdy = 1'b1;
    exp_gnt.push_back(1'b0);
    exp_cmd.push_back(mk_cmd(28'h40, CMD_WRITE));
    exp_wd.push_back(mk_wd({64{8'hA5}}, '0));
    fork
      client_run(0, 1'b1, 28'h40, 1, {64{8'hA5}}, '0);
      begin
        stalled = 0;
        repeat (4) begin @(negedge ui_clk); if (!app.app_en) stalled++; end
        chk("calib_low_no_cmd", stalled, 4);
        @(posedge ui_clk); #1;
        init_calib_complete = 1'b1;
        wait_en();
        chk("t1_write_beat", {app.app_wdf_wren, app.app_wdf_end, app.app_cmd}, {2'b11, CMD_WRITE});
        @(negedge ui_clk);
        chk("t1_one_cycle", {app.app_en, app.app_wdf_wren}, '0);
      end
    join

    // 2: read with app_rdy low for 5 cycles, then routed return.
    app.app_rdy = 1'b0;
    exp_gnt.push_back(1'b1);
    exp_cmd.push_back(mk_cmd(28'h80, CMD_READ));
    fork
      client_run(1, 1'b0, 28'h80, 1, '0, '0);
      begin
        wait_en();
        hold = 0;
        for (int unsigned k = 0; k < 5; k++) begin
          if (app.app_en && app.app_addr == 28'h80 && c_gnt == 2'b00) hold++;
          @(posedge ui_clk); #1;
          if (k == 4) app.app_rdy = 1'b1;
          @(negedge ui_clk);
        end
        if (app.app_en && app.app_addr == 28'h80) hold++;
        chk("t2_en_held", hold, 6);
        chk("t2_gnt_accept", c_gnt, 2'b10);
        @(negedge ui_clk);
        chk("t2_en_drops", app.app_en, 1'b0);
      end
    join
    rd_return(DW'(32'h1234), 2'b10);
    @(negedge ui_clk);
    chk("t2_rd_latency", {c_rd_valid, c_rd_data}, {2'b10, DW'(32'h1234)});
    @(negedge ui_clk);
    chk("t2_rd_valid_pulse", c_rd_valid, 2'b00);

    // 3: both clients stream reads; grants alternate and returns follow issue order.
    outstanding = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      a = (k[0] ? 28'h2000 : 28'h1000) + AW'((k / 2) * 16);
      exp_gnt.push_back(k[0]);
      exp_cmd.push_back(mk_cmd(a, CMD_READ));
    end
    fork
      client_run(0, 1'b0, 28'h1000, 4, '0, '0);
      client_run(1, 1'b0, 28'h2000, 4, '0, '0);
      for (int unsigned k = 0; k < 8; k++) begin
        t = 0;
        while (outstanding == 0 && t < 200) begin @(posedge ui_clk); #1; t++; end
        if (outstanding == 0) fail("t3_return_timeout", "timeout");
        else begin
          outstanding--;
          rd_return(DW'(32'hD000 + k), onehot2(k[0]));
        end
      end
    join
    repeat (2) @(negedge ui_clk);

    // 4: split write handshakes, both orders.
    t4_run(0, 1'b1, 28'h300, {16{32'hDEADBEEF}}, 64'hF0);
    t4_run(1, 1'b0, 28'h340, {16{32'h0BADF00D}}, 64'h0F00);

    // 5: tag FIFO full blocks reads but not writes.
    app.app_rdy = 1'b1; app.app_wdf_rdy = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      exp_gnt.push_back(1'b1);
      exp_cmd.push_back(mk_cmd(28'h500 + AW'(k * 16), CMD_READ));
    end
    client_run(1, 1'b0, 28'h500, 4, '0, '0);
    exp_gnt.push_back(1'b0);
    exp_cmd.push_back(mk_cmd(28'h600, CMD_WRITE));
    exp_wd.push_back(mk_wd({64{8'h3C}}, '0));
    exp_gnt.push_back(1'b1);
    exp_cmd.push_back(mk_cmd(28'h5F0, CMD_READ));
    fork
      client_run(1, 1'b0, 28'h5F0, 1, '0, '0);
      client_run(0, 1'b1, 28'h600, 1, {64{8'h3C}}, '0);
      begin
        t = 0;
        do begin @(negedge ui_clk); t++; end while (!c_gnt[0] && t < 100);
        if (!c_gnt[0]) fail("t5_write_timeout", "timeout");
        stalled = 0;
        repeat (5) begin @(negedge ui_clk); if (!app.app_en) stalled++; end
        chk("t5_read_blocked", stalled, 5);
        rd_return(DW'(32'h5500), 2'b10);
      end
    join
    for (int unsigned k = 0; k < 4; k++) rd_return(DW'(32'h5600 + k), 2'b10);
    repeat (2) @(negedge ui_clk);
    chk("rd_err_clean", rd_err, 1'b0);

    // 6: reset mid-ISSUE with two reads outstanding.
    exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b0);
    exp_cmd.push_back(mk_cmd(28'h700, CMD_READ));
    exp_cmd.push_back(mk_cmd(28'h710, CMD_READ));
    client_run(0, 1'b0, 28'h700, 2, '0, '0);
    app.app_rdy = 1'b0; app.app_wdf_rdy = 1'b0;
    @(posedge ui_clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 28'h7F0; wd1 = {64{8'h77}}; wm1 = '1;
    wait_en();
    #2;
    sys_rst = 1'b1; req1 = 1'b0;
    #1;
    chk("t6_rst_ctrl", {app.app_en, app.app_wdf_wren, app.app_wdf_end, c_gnt, c_rd_valid, rd_err}, '0);
    chk("t6_rst_bus", {app.app_addr, app.app_cmd, app.app_wdf_mask, c_rd_data}, '0);
    chk("t6_rst_wdata", app.app_wdf_data, '0);
    @(negedge ui_clk);
    sys_rst = 1'b0;
    app.app_rdy = 1'b1;
    rd_return(DW'(32'hBAD), 2'b00);
    @(negedge ui_clk);
    chk("t6_no_rd_valid", c_rd_valid, 2'b00);
    chk("t6_rd_err_set", rd_err, 1'b1);
    repeat (3) @(negedge ui_clk);
    chk("t6_rd_err_sticky", rd_err, 1'b1);

    chk("left_gnt", exp_gnt.size(), 0);
    chk("left_cmd", exp_cmd.size(), 0);
    chk("left_wdata", exp_wd.size(), 0);
    chk("left_rd", exp_rd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
